// File: rtl/rv32_d_decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_d_decode_stage_if
//  Description : Fetch-side and execute-side handshake bundle of the RV32
//                registered decode stage. The slave modport is the decode
//                stage itself; the master modport is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv32_d_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // fetch side
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [31:0]      instr_i;
    logic [XLEN-1:0]  pc_i;

    // execute side
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  pc_o;
    logic [4:0]       rd_o;
    logic [4:0]       rs1_o;
    logic [4:0]       rs2_o;
    logic [2:0]       funct3_o;
    logic             reg_write_o;
    logic             alu_src_a_o;
    logic             alu_src_b_o;
    logic             mem_write_o;
    logic             branch_o;
    logic             jump_o;
    logic             pc_target_src_o;
    logic [2:0]       imm_src_o;
    logic [1:0]       result_src_o;
    logic [1:0]       alu_op_o;
    logic [1:0]       unit_o;
    logic             csr_o;
    logic             illegal_o;
    logic [CNT_W-1:0] illegal_cnt_o;

    modport slave (
        input  flush_i, valid_i, instr_i, pc_i, ready_i,
        output ready_o, valid_o, pc_o, rd_o, rs1_o, rs2_o, funct3_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, mem_write_o,
               branch_o, jump_o, pc_target_src_o, imm_src_o,
               result_src_o, alu_op_o, unit_o, csr_o, illegal_o,
               illegal_cnt_o
    );

    modport master (
        output flush_i, valid_i, instr_i, pc_i, ready_i,
        input  ready_o, valid_o, pc_o, rd_o, rs1_o, rs2_o, funct3_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, mem_write_o,
               branch_o, jump_o, pc_target_src_o, imm_src_o,
               result_src_o, alu_op_o, unit_o, csr_o, illegal_o,
               illegal_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/rv32_d_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_d_decode_stage
//  Description : Registered RV32 main decoder with extension-unit select,
//                CSR / illegal flags, a 2-entry skid buffer between fetch
//                and execute, and a saturating illegal-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_d_decode_stage #(
    parameter int XLEN   = 32,
    parameter bit EN_M   = 1'b1,
    parameter bit EN_A   = 1'b1,
    parameter bit EN_F   = 1'b1,
    parameter bit EN_CSR = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rv32_d_decode_stage_if.slave  bus
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [6:0] OPC_ZERO     = 7'b0000000;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_UPASS  = 2'b11;

    localparam logic [1:0] UNIT_INT    = 2'b00;
    localparam logic [1:0] UNIT_MULDIV = 2'b01;
    localparam logic [1:0] UNIT_FPU    = 2'b10;
    localparam logic [1:0] UNIT_AMO    = 2'b11;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] ILL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ILL_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    // One decoded instruction as it travels through the skid buffer
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            reg_write;
        logic            alu_src_a;
        logic            alu_src_b;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            pc_target_src;
        logic [2:0]      imm_src;
        logic [1:0]      result_src;
        logic [1:0]      alu_op;
        logic [1:0]      unit;
        logic            csr;
        logic            illegal;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    entry_t     dec;

    // head_q feeds the outputs; skid_q holds the second entry when full
    entry_t             head_q,  head_d;
    entry_t             skid_q,  skid_d;
    logic [1:0]         count_q, count_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   ill_cnt_q, ill_cnt_d;
    logic               push;
    logic               pop;

    assign opcode = bus.instr_i[6:0];
    assign funct3 = bus.instr_i[14:12];
    assign funct7 = bus.instr_i[31:25];

    // Main decoder: controls stay zero for bubbles, FENCE and illegal words
    always_comb begin
        dec        = '0;
        dec.pc     = bus.pc_i;
        dec.rd     = bus.instr_i[11:7];
        dec.rs1    = bus.instr_i[19:15];
        dec.rs2    = bus.instr_i[24:20];
        dec.funct3 = funct3;
        case (opcode)
            OPC_ZERO, OPC_FENCE: begin
                dec.illegal = 1'b0;
            end
            OPC_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.imm_src    = IMM_I;
                dec.alu_src_b  = 1'b1;
                dec.result_src = RES_MEM;
            end
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.imm_src   = IMM_I;
                dec.alu_src_b = 1'b1;
                dec.alu_op    = ALU_FUNCT;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.imm_src   = IMM_U;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.alu_op    = ALU_UPASS;
            end
            OPC_STORE: begin
                dec.imm_src   = IMM_S;
                dec.alu_src_b = 1'b1;
                dec.mem_write = 1'b1;
            end
            OPC_OP: begin
                if ((funct7 == F7_BASE) || (funct7 == F7_ALT) ||
                    ((funct7 == F7_MULDIV) && EN_M)) begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = ALU_FUNCT;
                    if (funct7 == F7_MULDIV) begin
                        dec.unit = UNIT_MULDIV;
                    end
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.reg_write = 1'b1;
                dec.imm_src   = IMM_U;
                dec.alu_src_b = 1'b1;
                dec.alu_op    = ALU_UPASS;
            end
            OPC_BRANCH: begin
                dec.imm_src = IMM_B;
                dec.branch  = 1'b1;
                dec.alu_op  = ALU_BRANCH;
            end
            OPC_JALR: begin
                dec.reg_write     = 1'b1;
                dec.imm_src       = IMM_I;
                dec.alu_src_b     = 1'b1;
                dec.result_src    = RES_PC4;
                dec.alu_op        = ALU_ADD;
                dec.jump          = 1'b1;
                dec.pc_target_src = 1'b1;
            end
            OPC_JAL: begin
                dec.reg_write  = 1'b1;
                dec.imm_src    = IMM_J;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
            end
            OPC_SYSTEM: begin
                // ECALL/EBREAK/xRET (funct3=000) decode as a no-op bundle
                if (EN_CSR && (funct3 != 3'b000)) begin
                    dec.csr       = 1'b1;
                    dec.reg_write = 1'b1;
                end
            end
            OPC_AMO: begin
                if (EN_A) begin
                    dec.unit       = UNIT_AMO;
                    dec.reg_write  = 1'b1;
                    dec.result_src = RES_MEM;
                    dec.imm_src    = IMM_I;
                    dec.alu_src_b  = 1'b0;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_LOAD_FP: begin
                if (EN_F) begin
                    dec.unit       = UNIT_FPU;
                    dec.reg_write  = 1'b1;
                    dec.imm_src    = IMM_I;
                    dec.alu_src_b  = 1'b1;
                    dec.result_src = RES_MEM;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_STORE_FP: begin
                if (EN_F) begin
                    dec.unit      = UNIT_FPU;
                    dec.imm_src   = IMM_S;
                    dec.alu_src_b = 1'b1;
                    dec.mem_write = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_FP: begin
                if (EN_F) begin
                    dec.unit      = UNIT_FPU;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = ALU_FUNCT;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // push is gated by the registered ready so a full buffer never overflows
    assign push = bus.valid_i & ready_q & ~bus.flush_i;
    assign pop  = (count_q != CNT_EMPTY) & bus.ready_i;

    // Skid-buffer and counter next state; flush overrides every other event
    always_comb begin
        head_d    = head_q;
        skid_d    = skid_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;
        if (bus.flush_i) begin
            count_d = CNT_EMPTY;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == CNT_EMPTY) begin
                        head_d  = dec;
                        count_d = CNT_ONE;
                    end else begin
                        skid_d  = dec;
                        count_d = CNT_FULL;
                    end
                end
                2'b01: begin
                    if (count_q == CNT_FULL) begin
                        head_d  = skid_q;
                        count_d = CNT_ONE;
                    end else begin
                        // head_q keeps the popped entry; valid_o drops
                        count_d = CNT_EMPTY;
                    end
                end
                2'b11: begin
                    // only reachable with one entry stored
                    head_d = dec;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
            if (push && dec.illegal && (ill_cnt_q != ILL_MAX)) begin
                ill_cnt_d = ill_cnt_q + ILL_INC;
            end
        end
    end

    assign ready_d = (count_d != CNT_FULL);

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q    <= '0;
            skid_q    <= '0;
            count_q   <= CNT_EMPTY;
            ready_q   <= 1'b1;
            ill_cnt_q <= '0;
        end else begin
            head_q    <= head_d;
            skid_q    <= skid_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign bus.ready_o         = ready_q;
    assign bus.valid_o         = (count_q != CNT_EMPTY);
    assign bus.pc_o            = head_q.pc;
    assign bus.rd_o            = head_q.rd;
    assign bus.rs1_o           = head_q.rs1;
    assign bus.rs2_o           = head_q.rs2;
    assign bus.funct3_o        = head_q.funct3;
    assign bus.reg_write_o     = head_q.reg_write;
    assign bus.alu_src_a_o     = head_q.alu_src_a;
    assign bus.alu_src_b_o     = head_q.alu_src_b;
    assign bus.mem_write_o     = head_q.mem_write;
    assign bus.branch_o        = head_q.branch;
    assign bus.jump_o          = head_q.jump;
    assign bus.pc_target_src_o = head_q.pc_target_src;
    assign bus.imm_src_o       = head_q.imm_src;
    assign bus.result_src_o    = head_q.result_src;
    assign bus.alu_op_o        = head_q.alu_op;
    assign bus.unit_o          = head_q.unit;
    assign bus.csr_o           = head_q.csr;
    assign bus.illegal_o       = head_q.illegal;
    assign bus.illegal_cnt_o   = ill_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_d_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_d_decode_stage
//  Description : Self-checking bench for rv32_d_decode_stage. dut_a has M
//                enabled and a 16-bit counter; dut_b has M disabled and a
//                3-bit counter so saturation is reachable quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rv32_d_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32_d_decode_stage_if #(.XLEN(32), .CNT_W(16)) bus_a ();
    rv32_d_decode_stage_if #(.XLEN(32), .CNT_W(3))  bus_b ();

    rv32_d_decode_stage #(.XLEN(32), .EN_M(1'b1), .EN_A(1'b1), .EN_F(1'b1),
                          .EN_CSR(1'b1), .CNT_W(16))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));

    rv32_d_decode_stage #(.XLEN(32), .EN_M(1'b0), .EN_A(1'b1), .EN_F(1'b1),
                          .EN_CSR(1'b1), .CNT_W(3))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    // Control vector order:
    // {reg_write, imm_src[2:0], src_a, src_b, mem_write, result_src[1:0],
    //  branch, alu_op[1:0], jump, pc_target_src}
    localparam logic [13:0] C_LOAD  = 14'b1_000_0_1_0_01_0_00_0_0;
    localparam logic [13:0] C_OPIMM = 14'b1_000_0_1_0_00_0_10_0_0;
    localparam logic [13:0] C_AUIPC = 14'b1_100_1_1_0_00_0_11_0_0;
    localparam logic [13:0] C_STORE = 14'b0_001_0_1_1_00_0_00_0_0;
    localparam logic [13:0] C_OP    = 14'b1_000_0_0_0_00_0_10_0_0;
    localparam logic [13:0] C_LUI   = 14'b1_100_0_1_0_00_0_11_0_0;
    localparam logic [13:0] C_BR    = 14'b0_010_0_0_0_00_1_01_0_0;
    localparam logic [13:0] C_JALR  = 14'b1_000_0_1_0_10_0_00_1_1;
    localparam logic [13:0] C_JAL   = 14'b1_011_0_0_0_10_0_00_1_0;
    localparam logic [13:0] C_CSR   = 14'b1_000_0_0_0_00_0_00_0_0;
    localparam logic [13:0] C_AMO   = 14'b1_000_0_0_0_01_0_00_0_0;

    localparam logic [6:0] OPS [17] = '{7'h00, 7'h03, 7'h0F, 7'h13, 7'h17,
                                        7'h23, 7'h33, 7'h37, 7'h63, 7'h67,
                                        7'h6F, 7'h73, 7'h2F, 7'h07, 7'h27,
                                        7'h53, 7'h7F};

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [13:0] ctrl;
        logic [1:0]  unit;
        logic        csr;
        logic        ill;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mcnt_a  = '0;
    logic [2:0]  mcnt_b  = '0;

    // Reference decode taken straight from the opcode table
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input bit en_m);
        exp_t e;
        logic [6:0] op;
        logic [6:0] f7;
        op     = ins[6:0];
        f7     = ins[31:25];
        e      = '0;
        e.pc   = pc;
        e.rd   = ins[11:7];
        e.rs1  = ins[19:15];
        e.rs2  = ins[24:20];
        e.f3   = ins[14:12];
        case (op)
            7'h00, 7'h0F: e.ctrl = '0;
            7'h03: e.ctrl = C_LOAD;
            7'h13: e.ctrl = C_OPIMM;
            7'h17: e.ctrl = C_AUIPC;
            7'h23: e.ctrl = C_STORE;
            7'h33: begin
                if (f7 == 7'h00 || f7 == 7'h20) e.ctrl = C_OP;
                else if (f7 == 7'h01 && en_m) begin e.ctrl = C_OP; e.unit = 2'b01; end
                else e.ill = 1'b1;
            end
            7'h37: e.ctrl = C_LUI;
            7'h63: e.ctrl = C_BR;
            7'h67: e.ctrl = C_JALR;
            7'h6F: e.ctrl = C_JAL;
            7'h73: if (ins[14:12] != 3'b000) begin e.ctrl = C_CSR; e.csr = 1'b1; end
            7'h2F: begin e.ctrl = C_AMO;   e.unit = 2'b11; end
            7'h07: begin e.ctrl = C_LOAD;  e.unit = 2'b10; end
            7'h27: begin e.ctrl = C_STORE; e.unit = 2'b10; end
            7'h53: begin e.ctrl = C_OP;    e.unit = 2'b10; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic exp_t obs_a();
        exp_t e;
        e.pc   = bus_a.pc_o;  e.rd = bus_a.rd_o; e.rs1 = bus_a.rs1_o;
        e.rs2  = bus_a.rs2_o; e.f3 = bus_a.funct3_o;
        e.ctrl = {bus_a.reg_write_o, bus_a.imm_src_o, bus_a.alu_src_a_o,
                  bus_a.alu_src_b_o, bus_a.mem_write_o, bus_a.result_src_o,
                  bus_a.branch_o, bus_a.alu_op_o, bus_a.jump_o,
                  bus_a.pc_target_src_o};
        e.unit = bus_a.unit_o; e.csr = bus_a.csr_o; e.ill = bus_a.illegal_o;
        return e;
    endfunction

    function automatic exp_t obs_b();
        exp_t e;
        e.pc   = bus_b.pc_o;  e.rd = bus_b.rd_o; e.rs1 = bus_b.rs1_o;
        e.rs2  = bus_b.rs2_o; e.f3 = bus_b.funct3_o;
        e.ctrl = {bus_b.reg_write_o, bus_b.imm_src_o, bus_b.alu_src_a_o,
                  bus_b.alu_src_b_o, bus_b.mem_write_o, bus_b.result_src_o,
                  bus_b.branch_o, bus_b.alu_op_o, bus_b.jump_o,
                  bus_b.pc_target_src_o};
        e.unit = bus_b.unit_o; e.csr = bus_b.csr_o; e.ill = bus_b.illegal_o;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 17);
        if (k < 17) w[6:0] = OPS[k];
        if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: w[31:25] = w[31:25];
            endcase
        end
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (bus_a.valid_o !== 1'b0 || bus_a.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs: valid=%b ready=%b want 0/1", bus_a.valid_o, bus_a.ready_o);
        end
        n_tests++;
        if (bus_a.illegal_cnt_o !== 16'd0 || bus_b.illegal_cnt_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: a=%0d b=%0d want 0", bus_a.illegal_cnt_o, bus_b.illegal_cnt_o);
        end
        n_tests++;
        if (obs_a() !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL reset_out: got %h want 0", obs_a());
        end
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [31:0] ins;
        logic [31:0] pc;
        bit          v, rdy, fl, acc;
        for (int i = 0; i < 400; i++) begin
            n_tests++;
            if (bus_a.valid_o !== (q.size() != 0) || bus_a.ready_o !== (q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_hs cyc %0d: valid=%b ready=%b want entries=%0d",
                         i, bus_a.valid_o, bus_a.ready_o, q.size());
            end
            n_tests++;
            if (bus_a.illegal_cnt_o !== mcnt_a) begin
                n_fail++;
                $display("FAIL rand_cnt cyc %0d: got %0d want %0d", i, bus_a.illegal_cnt_o, mcnt_a);
            end
            if (q.size() != 0) begin
                n_tests++;
                if (obs_a() !== q[0]) begin
                    n_fail++;
                    $display("FAIL rand_out cyc %0d: got %h want %h", i, obs_a(), q[0]);
                end
            end
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            ins = rand_instr();
            pc  = $urandom;
            bus_a.valid_i = v; bus_a.ready_i = rdy; bus_a.flush_i = fl;
            bus_a.instr_i = ins; bus_a.pc_i = pc;
            if (fl) begin
                q.delete();
            end else begin
                acc = v && (q.size() < 2);
                if (q.size() != 0 && rdy) void'(q.pop_front());
                if (acc) begin
                    e = model(ins, pc, 1'b1);
                    q.push_back(e);
                    if (e.ill && mcnt_a != 16'hFFFF) mcnt_a = mcnt_a + 16'd1;
                end
            end
            cyc();
        end
        bus_a.valid_i = 1'b0; bus_a.flush_i = 1'b1; bus_a.ready_i = 1'b1;
        cyc();
        bus_a.flush_i = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] prog [3];
        exp_t        e;
        prog[0] = 32'h00500093; prog[1] = 32'h0000A103; prog[2] = 32'h000080E7;
        bus_a.ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_a.valid_i = 1'b1; bus_a.instr_i = prog[i]; bus_a.pc_i = 32'h100 + 32'(4 * i);
            cyc();
            e = model(prog[i], 32'h100 + 32'(4 * i), 1'b1);
            n_tests++;
            if (bus_a.valid_o !== 1'b1 || obs_a() !== e) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b got %h want %h", i, bus_a.valid_o, obs_a(), e);
            end
        end
        bus_a.valid_i = 1'b0;
        n_tests++;
        if (bus_a.jump_o !== 1'b1 || bus_a.pc_target_src_o !== 1'b1 || bus_a.result_src_o !== 2'b10) begin
            n_fail++;
            $display("FAIL stream_jalr: jump=%b pts=%b res=%b want 1/1/10",
                     bus_a.jump_o, bus_a.pc_target_src_o, bus_a.result_src_o);
        end
        cyc();
        n_tests++;
        if (bus_a.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: valid=%b want 0", bus_a.valid_o);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        for (int i = 0; i < 3; i++) w[i] = {$urandom_range(0, 4095), 20'h00013} | 32'h00000F80;
        bus_a.ready_i = 1'b0;
        bus_a.valid_i = 1'b1; bus_a.instr_i = w[0]; bus_a.pc_i = 32'h200;
        cyc();
        bus_a.instr_i = w[1]; bus_a.pc_i = 32'h204;
        cyc();
        bus_a.instr_i = w[2]; bus_a.pc_i = 32'h208;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus_a.ready_o !== 1'b0 || bus_a.valid_o !== 1'b1 || obs_a() !== model(w[0], 32'h200, 1'b1)) begin
                n_fail++;
                $display("FAIL bp_full_%0d: ready=%b valid=%b got %h", i, bus_a.ready_o, bus_a.valid_o, obs_a());
            end
            cyc();
        end
        bus_a.ready_i = 1'b1;
        cyc();
        n_tests++;
        if (obs_a() !== model(w[1], 32'h204, 1'b1) || bus_a.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: ready=%b got %h", bus_a.ready_o, obs_a());
        end
        cyc();
        bus_a.valid_i = 1'b0;
        n_tests++;
        if (obs_a() !== model(w[2], 32'h208, 1'b1) || bus_a.valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_third: valid=%b got %h", bus_a.valid_o, obs_a());
        end
        cyc();
        n_tests++;
        if (bus_a.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: valid=%b want 0", bus_a.valid_o);
        end
    endtask

    task automatic test_mul();
        exp_t ea, eb;
        ea = model(32'h02208033, 32'h300, 1'b1);
        eb = model(32'h02208033, 32'h300, 1'b0);
        bus_a.ready_i = 1'b1; bus_b.ready_i = 1'b1;
        bus_a.valid_i = 1'b1; bus_a.instr_i = 32'h02208033; bus_a.pc_i = 32'h300;
        bus_b.valid_i = 1'b1; bus_b.instr_i = 32'h02208033; bus_b.pc_i = 32'h300;
        cyc();
        bus_a.valid_i = 1'b0; bus_b.valid_i = 1'b0;
        mcnt_b = mcnt_b + 3'd1;
        n_tests++;
        if (bus_a.unit_o !== 2'b01 || bus_a.illegal_o !== 1'b0 || obs_a() !== ea) begin
            n_fail++;
            $display("FAIL mul_en: unit=%b ill=%b got %h want %h", bus_a.unit_o, bus_a.illegal_o, obs_a(), ea);
        end
        n_tests++;
        if (bus_b.illegal_o !== 1'b1 || bus_b.reg_write_o !== 1'b0 || bus_b.alu_op_o !== 2'b00 ||
            bus_b.unit_o !== 2'b00 || obs_b() !== eb) begin
            n_fail++;
            $display("FAIL mul_dis: got %h want %h", obs_b(), eb);
        end
        n_tests++;
        if (bus_b.illegal_cnt_o !== mcnt_b || bus_a.illegal_cnt_o !== mcnt_a) begin
            n_fail++;
            $display("FAIL mul_cnt: b=%0d want %0d a=%0d want %0d",
                     bus_b.illegal_cnt_o, mcnt_b, bus_a.illegal_cnt_o, mcnt_a);
        end
        cyc();
    endtask

    task automatic test_flush();
        logic [31:0] nw;
        nw = 32'h00A00513;
        bus_a.ready_i = 1'b0; bus_a.valid_i = 1'b1;
        bus_a.instr_i = 32'h00100093; bus_a.pc_i = 32'h400;
        cyc();
        bus_a.instr_i = 32'h00200113; bus_a.pc_i = 32'h404;
        cyc();
        bus_a.instr_i = 32'hFFFFFFFF; bus_a.pc_i = 32'h408; bus_a.flush_i = 1'b1;
        cyc();
        n_tests++;
        if (bus_a.valid_o !== 1'b0 || bus_a.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_hs: valid=%b ready=%b want 0/1", bus_a.valid_o, bus_a.ready_o);
        end
        cyc();
        bus_a.flush_i = 1'b0;
        n_tests++;
        if (bus_a.valid_o !== 1'b0 || bus_a.illegal_cnt_o !== mcnt_a) begin
            n_fail++;
            $display("FAIL flush_drop: valid=%b cnt=%0d want 0/%0d", bus_a.valid_o, bus_a.illegal_cnt_o, mcnt_a);
        end
        bus_a.ready_i = 1'b1; bus_a.instr_i = nw; bus_a.pc_i = 32'h40C;
        cyc();
        bus_a.valid_i = 1'b0;
        n_tests++;
        if (bus_a.valid_o !== 1'b1 || obs_a() !== model(nw, 32'h40C, 1'b1)) begin
            n_fail++;
            $display("FAIL flush_next: valid=%b got %h", bus_a.valid_o, obs_a());
        end
        cyc();
        n_tests++;
        if (bus_a.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stale: valid=%b want 0", bus_a.valid_o);
        end
    endtask

    task automatic test_saturate();
        bus_b.ready_i = 1'b1;
        bus_b.valid_i = 1'b1;
        while (mcnt_b < 3'd6) begin
            bus_b.instr_i = {$urandom_range(0, 1000), 7'h0B}; bus_b.pc_i = $urandom;
            cyc();
            mcnt_b = mcnt_b + 3'd1;
        end
        n_tests++;
        if (bus_b.illegal_cnt_o !== 3'd6) begin
            n_fail++;
            $display("FAIL sat_pre: got %0d want 6", bus_b.illegal_cnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            bus_b.instr_i = 32'hFFFFFFFF;
            cyc();
            if (mcnt_b != 3'd7) mcnt_b = mcnt_b + 3'd1;
            n_tests++;
            if (bus_b.illegal_cnt_o !== mcnt_b || bus_b.illegal_o !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_%0d: cnt=%0d want %0d ill=%b", i, bus_b.illegal_cnt_o, mcnt_b, bus_b.illegal_o);
            end
        end
        bus_b.valid_i = 1'b0;
        cyc();
        n_tests++;
        if (bus_b.illegal_cnt_o !== 3'd7) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d want 7", bus_b.illegal_cnt_o);
        end
    endtask

    task automatic test_async_reset();
        bus_a.ready_i = 1'b0; bus_a.valid_i = 1'b1;
        bus_a.instr_i = 32'hFFFFFFFF; bus_a.pc_i = 32'h500;
        cyc();
        bus_a.instr_i = 32'h00300193; bus_a.pc_i = 32'h504;
        cyc();
        bus_a.valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus_a.valid_o !== 1'b0 || bus_a.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_hs: valid=%b ready=%b want 0/1", bus_a.valid_o, bus_a.ready_o);
        end
        n_tests++;
        if (bus_a.illegal_cnt_o !== 16'd0 || bus_b.illegal_cnt_o !== 3'd0 || obs_a() !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL areset_state: cnt_a=%0d cnt_b=%0d out=%h", bus_a.illegal_cnt_o,
                     bus_b.illegal_cnt_o, obs_a());
        end
        @(negedge clk);
        rst = 1'b0;
        cyc();
        n_tests++;
        if (bus_a.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_after: valid=%b want 0", bus_a.valid_o);
        end
    endtask

    initial begin
        bus_a.flush_i = 1'b0; bus_a.valid_i = 1'b0; bus_a.ready_i = 1'b1;
        bus_a.instr_i = '0;   bus_a.pc_i    = '0;
        bus_b.flush_i = 1'b0; bus_b.valid_i = 1'b0; bus_b.ready_i = 1'b1;
        bus_b.instr_i = '0;   bus_b.pc_i    = '0;
        test_reset();
        test_random();
        test_stream();
        test_backpressure();
        test_mul();
        test_flush();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/rv32_d_decode_stage.md
# rv32_d_decode_stage

Registered, handshaked decode stage that replaces the purely combinational main decoder in the RV32 pipeline. It accepts a fetched instruction and PC, and decodes opcode, funct3 and funct7 into the standard control bundle plus extension-unit select, CSR and illegal flags. Results are buffered in a 2-entry skid buffer between fetch and execute. M/A/F/Zicsr decode is enabled per parameter; a saturating counter tracks illegal instructions.

## Interface
- `XLEN`, 32: PC width.
- `EN_M`, 1: decode OP with funct7=0000001 as mul/div.
- `EN_A`, 1: decode AMO opcode 0101111.
- `EN_F`, 1: decode LOAD-FP 0000111, STORE-FP 0100111, OP-FP 1010011.
- `EN_CSR`, 1: decode SYSTEM with funct3≠000 as CSR.
- `CNT_W`, 16: illegal counter width.
- `clk_i` in 1: clock.
- `rst_i` in 1: **one clock; reset is asynchronous and active-high**.
- `flush_i` in 1: discard buffered and incoming entries.
- `valid_i` in 1, `ready_o` out 1: input handshake.
- `instr_i` in 32: instruction. `pc_i` in XLEN: its PC.
- `valid_o` out 1, `ready_i` in 1: output handshake.
- `pc_o` out XLEN; `rd_o`, `rs1_o`, `rs2_o` out 5 each; `funct3_o` out 3.
- `reg_write_o`, `alu_src_a_o`, `alu_src_b_o`, `mem_write_o`, `branch_o`, `jump_o`, `pc_target_src_o` out 1 each.
- `imm_src_o` out 3; `result_src_o` out 2; `alu_op_o` out 2.
- `unit_o` out 2: 00 int, 01 muldiv, 10 fpu, 11 amo. `csr_o` out 1. `illegal_o` out 1.
- `illegal_cnt_o` out CNT_W.

## Operation
- Encodings:
  - imm_src: I=000, S=001, B=010, J=011, U=100.
  - result_src: 00 ALU, 01 mem, 10 PC+4.
  - alu_op: 00 add, 01 branch, 10 funct, 11 U-pass.
- Control by opcode (reg_write/imm_src/src_a/src_b/mem_write/result_src/branch/alu_op/jump/pc_target_src):
  - 0000000 all zero (bubble, not illegal).
  - LOAD 0000011: 1/000/0/1/0/01/0/00/0/0.
  - FENCE 0001111: all zero.
  - OP-IMM 0010011: 1/000/0/1/0/00/0/10/0/0.
  - AUIPC 0010111: 1/100/1/1/0/00/0/11/0/0.
  - STORE 0100011: 0/001/0/1/1/00/0/00/0/0.
  - OP 0110011: 1/000/0/0/0/00/0/10/0/0.
  - LUI 0110111: 1/100/0/1/0/00/0/11/0/0.
  - BRANCH 1100011: 0/010/0/0/0/00/1/01/0/0.
  - JALR 1100111: 1/000/0/1/0/10/0/00/1/1.
  - JAL 1101111: 1/011/0/0/0/10/0/00/1/0.
  - SYSTEM 1110011: all zero; csr_o=1 and reg_write=1 if EN_CSR and funct3≠000.
- Extensions (unit_o):
  - OP with funct7=0000001 and EN_M: unit 01.
  - AMO with EN_A: unit 11, reg_write=1, result_src=01, imm_src=000, src_b=0.
  - LOAD-FP: LOAD controls with unit 10.
  - STORE-FP: STORE controls with unit 10.
  - OP-FP: OP controls with unit 10.
- Illegal: any other opcode, an extension opcode with its parameter 0, or OP funct7 not in {0000000, 0100000, 0000001 with EN_M}.
  - Forces all controls zero and unit 00, illegal_o=1.
  - rd/rs/pc still passed through.
- Field pass-through: rd=instr[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12].
- illegal_cnt_o increments by 1 on each accepted illegal instruction and saturates at all-ones.

## Timing
- Input accepted on an edge where valid_i & ready_o & !flush_i. Output consumed on an edge where valid_o & ready_i.
- Latency: decode is registered; an accepted instruction appears at the outputs on the next cycle with valid_o=1.
- Skid buffer holds 2 entries, FIFO order. ready_o is driven from a register and equals "fewer than 2 entries".
  - Simultaneous accept and consume with 2 entries stored cannot occur, because ready_o=0.
  - With 1 entry stored, the count stays 1 and the head advances.
- Full: ready_o=0 and contents are held while ready_i=0. Outputs remain stable while valid_o & !ready_i.
- Empty: valid_o=0. Outputs then show the last popped entry (or reset values) and must not be relied on.
- flush_i: on the next edge the count becomes 0, valid_o=0, ready_o=1, and any input presented that cycle is dropped. The counter is not affected by dropped instructions. flush_i has priority over all other events.
- Reset (asynchronous, any time): count=0, valid_o=0, ready_o=1, illegal_cnt_o=0, all decoded outputs and pc_o zero. Any in-flight entry is lost.

## Test plan
- Reset mid-stream with 2 entries buffered -> valid_o=0, ready_o=1, illegal_cnt_o=0 immediately, without waiting for a clock edge.
- Stream ADDI 0x00500093, LW 0x0000A103, JALR 0x000080E7 with ready_i=1 -> one per cycle, latency 1.
  - ADDI: reg_write=1, alu_op=10, src_b=1.
  - LW: result_src=01.
  - JALR: jump=1, pc_target_src=1, result_src=10.
- Hold ready_i=0 for 4 cycles while sending 3 instructions -> ready_o=0 after 2 accepts; the third instruction is accepted only after ready_i rises; order is preserved.
- MUL 0x02208033 with EN_M=1 -> unit_o=01, illegal_o=0. With EN_M=0 -> illegal_o=1, all controls 0, counter +1.
- Assert flush_i with 2 entries buffered and valid_i=1 -> next cycle valid_o=0. Only instructions sent after the flush appear.
- Force counter to all-ones minus 1, then send 3 opcode-1111111 words -> counter saturates at all-ones.
